// File: rtl/mpeg2_pkg.sv
// Shared definitions for the macroblock scheduler: FSM encoding,
// blocks-per-macroblock count and colour-component codes.
package mpeg2_pkg;

    // Four luma blocks plus one Cb and one Cr block per 4:2:0 macroblock.
    localparam int NUM_BLK = 6;

    localparam logic [1:0] CC_LUMA = 2'd0;
    localparam logic [1:0] CC_CB   = 2'd1;
    localparam logic [1:0] CC_CR   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEL     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_LAUNCH  = 3'd3,
        ST_RUN     = 3'd4,
        ST_RELEASE = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Block index to colour component: 0-3 luma, 4 Cb, 5 Cr.
    function automatic logic [1:0] blk_to_cc(input logic [2:0] blk);
        logic [1:0] cc;
        case (blk)
            3'd4:    cc = CC_CB;
            3'd5:    cc = CC_CR;
            default: cc = CC_LUMA;
        endcase
        return cc;
    endfunction

endpackage

// File: rtl/mb_sched_if.sv
// Bundle of the macroblock handshake, DCT buffer handshake and encoder
// control signals around the scheduler.
interface mb_sched_if;

    logic       mb_start;
    logic       mb_intra;
    logic [5:0] mb_cbp;
    logic       mb_busy;
    logic       mb_done;
    logic       buf_valid;
    logic [2:0] buf_blk;
    logic       buf_release;
    logic       rle_rdy;
    logic       rle_en;
    logic       rle_intra;
    logic       h_en;
    logic       h_end;
    logic [1:0] blk_cc;
    logic [2:0] blk_cnt;

    // Surrounding pipeline: issues macroblocks, owns buffers and encoder.
    modport master (
        output mb_start, mb_intra, mb_cbp, buf_valid, rle_rdy, h_en, h_end,
        input  mb_busy, mb_done, buf_blk, buf_release, rle_en, rle_intra,
               blk_cc, blk_cnt
    );

    // The scheduler itself.
    modport slave (
        input  mb_start, mb_intra, mb_cbp, buf_valid, rle_rdy, h_en, h_end,
        output mb_busy, mb_done, buf_blk, buf_release, rle_en, rle_intra,
               blk_cc, blk_cnt
    );

endinterface

// File: rtl/mb_blk_sel.sv
// Next-coded-block search: lowest set bit of mask at or above ptr.
// A pointer of 6 or 7 never matches, which is how the scheduler ends.
module mb_blk_sel
    import mpeg2_pkg::*;
(
    input  logic [5:0] mask,
    input  logic [2:0] ptr,
    output logic [2:0] idx,
    output logic       found
);

    // Scan from the top down so the lowest qualifying index wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_BLK - 1; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= ptr)) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mb_sched.sv
// Macroblock scheduler: walks the coded blocks of one macroblock, waits
// for each DCT buffer and an idle encoder, launches the encoder, waits for
// its end-of-block hash strobe and releases the buffer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for mb_start; latches intra flag and block mask
// SEL        | pick next coded block at/above pointer, or finish
// WAIT       | wait for buffer valid and encoder ready together
// LAUNCH     | one-cycle rle_en
// RUN        | encoder busy until h_en and h_end coincide
// RELEASE    | one-cycle buf_release, count block, advance pointer
// DONE       | one-cycle mb_done, back to IDLE
module mb_sched
    import mpeg2_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    mb_sched_if.slave bus
);

    state_t     state;
    state_t     state_nx;
    logic [5:0] mask;
    logic [2:0] ptr;
    logic [2:0] blk;
    logic [2:0] cnt;
    logic       intra_q;
    logic [2:0] sel_idx;
    logic       sel_found;

    mb_blk_sel u_blk_sel (
        .mask  (mask),
        .ptr   (ptr),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; mb_start is only looked at in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (bus.mb_start) state_nx = ST_SEL;
            ST_SEL:     state_nx = sel_found ? ST_WAIT : ST_DONE;
            ST_WAIT:    if (bus.buf_valid && bus.rle_rdy) state_nx = ST_LAUNCH;
            ST_LAUNCH:  state_nx = ST_RUN;
            ST_RUN:     if (bus.h_en && bus.h_end) state_nx = ST_RELEASE;
            ST_RELEASE: state_nx = ST_SEL;
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Macroblock context: mask, search pointer, current block, count, intra.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask    <= '0;
            ptr     <= '0;
            blk     <= '0;
            cnt     <= '0;
            intra_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.mb_start) begin
                        intra_q <= bus.mb_intra;
                        mask    <= bus.mb_intra ? 6'b111111 : bus.mb_cbp;
                        cnt     <= '0;
                        ptr     <= '0;
                    end
                end
                ST_SEL: begin
                    if (sel_found) blk <= sel_idx;
                end
                ST_RELEASE: begin
                    cnt <= cnt + 3'd1;
                    ptr <= blk + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Pulses and status decode from the state register only.
    assign bus.mb_busy     = (state != ST_IDLE);
    assign bus.mb_done     = (state == ST_DONE);
    assign bus.rle_en      = (state == ST_LAUNCH);
    assign bus.buf_release = (state == ST_RELEASE);
    assign bus.buf_blk     = blk;
    assign bus.blk_cnt     = cnt;
    assign bus.rle_intra   = intra_q;
    assign bus.blk_cc      = blk_to_cc(blk);

    // Encoder start and end-of-macroblock are strictly single-cycle.
    a_rle_en_pulse : assert property (@(posedge clk) disable iff (reset)
        bus.rle_en |=> !bus.rle_en);
    a_done_pulse : assert property (@(posedge clk) disable iff (reset)
        bus.mb_done |=> !bus.mb_done);

    // The encoder must see a constant intra flag for the whole macroblock.
    a_intra_stable : assert property (@(posedge clk) disable iff (reset)
        (bus.mb_busy && $past(bus.mb_busy)) |-> $stable(bus.rle_intra));

endmodule

// File: tb/tb_mb_sched.sv
// Directed bench for mb_sched with a simple reactive encoder stand-in.
module tb_mb_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    localparam int HDELAY = 5;

    mb_sched_if bus ();

    mb_sched dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Results of the last run_mb call.
    int         n_en, n_rel, n_done, done_cyc, busy_cyc, last_cnt, intra_bad;
    logic [2:0] seen_blk [0:7];
    logic [1:0] seen_cc  [0:7];
    bit         timed_out;

    task automatic chk(input string tag, input integer got, input integer exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one macroblock and play encoder until mb_done. abort_en > 0
    // asserts reset in the RUN cycle after that many rle_en pulses;
    // glitch pulses a conflicting mb_start in the first RUN cycle.
    task automatic run_mb(input logic intra, input logic [5:0] cbp,
                          input int abort_en, input bit glitch);
        int  cd;
        int  cyc;
        bit  gpend;
        bit  apend;
        n_en = 0; n_rel = 0; n_done = 0; done_cyc = -1; busy_cyc = 0;
        last_cnt = -1; intra_bad = 0; timed_out = 1'b1;
        cd = -1; gpend = 1'b0; apend = 1'b0;
        bus.mb_intra = intra;
        bus.mb_cbp   = cbp;
        bus.mb_start = 1'b1;
        step();
        cyc = 1;
        while (cyc <= 400) begin
            bus.mb_start = 1'b0;
            bus.mb_intra = 1'b0;
            bus.mb_cbp   = '0;
            bus.h_en     = 1'b0;
            bus.h_end    = 1'b0;
            if (apend) begin
                rst = 1'b1;
                timed_out = 1'b0;
                return;
            end
            if (gpend) begin
                bus.mb_start = 1'b1;
                bus.mb_intra = 1'b1;
                bus.mb_cbp   = 6'b000001;
                gpend = 1'b0;
            end
            if (bus.mb_busy) busy_cyc++;
            if (bus.mb_busy && bus.rle_intra !== intra) intra_bad++;
            if (bus.buf_release) n_rel++;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.h_en  = 1'b1;
                    bus.h_end = 1'b1;
                end
            end
            if (bus.rle_en) begin
                if (n_en < 8) begin
                    seen_blk[n_en] = bus.buf_blk;
                    seen_cc[n_en]  = bus.blk_cc;
                end
                n_en++;
                cd = HDELAY;
                if (glitch && n_en == 1) gpend = 1'b1;
                if (abort_en > 0 && n_en == abort_en) apend = 1'b1;
            end
            if (bus.mb_done) begin
                n_done++;
                done_cyc  = cyc;
                last_cnt  = bus.blk_cnt;
                timed_out = 1'b0;
                bus.h_en  = 1'b0;
                bus.h_end = 1'b0;
                return;
            end
            step();
            cyc++;
        end
    endtask

    task automatic check_blocks(input string pfx, input int n,
                                input int eb [6], input int ec [6]);
        chk({pfx, "_n_en"}, n_en, n);
        for (int i = 0; i < n && i < n_en; i++) begin
            chk($sformatf("%s_blk%0d", pfx, i), seen_blk[i], eb[i]);
            chk($sformatf("%s_cc%0d", pfx, i), seen_cc[i], ec[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=hang want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int eb [6];
        int ec [6];
        int early;
        int cnt;

        bus.mb_start = 1'b0; bus.mb_intra = 1'b0; bus.mb_cbp = '0;
        bus.buf_valid = 1'b1; bus.rle_rdy = 1'b1;
        bus.h_en = 1'b0; bus.h_end = 1'b0;

        // Reset state, sampled while reset is still held.
        repeat (3) step();
        chk("rst_busy",  bus.mb_busy, 0);
        chk("rst_done",  bus.mb_done, 0);
        chk("rst_en",    bus.rle_en, 0);
        chk("rst_rel",   bus.buf_release, 0);
        chk("rst_blk",   bus.buf_blk, 0);
        chk("rst_cnt",   bus.blk_cnt, 0);
        chk("rst_intra", bus.rle_intra, 0);
        chk("rst_cc",    bus.blk_cc, 0);
        rst = 1'b0;
        step();

        // Intra macroblock: cbp ignored, all six blocks in order.
        run_mb(1'b1, 6'b000000, 0, 1'b0);
        chk("intra_to", timed_out, 0);
        eb = '{0, 1, 2, 3, 4, 5};
        ec = '{0, 0, 0, 0, 1, 2};
        check_blocks("intra", 6, eb, ec);
        chk("intra_cnt", last_cnt, 6);
        chk("intra_rel", n_rel, 6);
        chk("intra_done", n_done, 1);
        chk("intra_flag", intra_bad, 0);
        step();

        // Non-intra cbp 100101: blocks 0, 2, 5.
        run_mb(1'b0, 6'b100101, 0, 1'b0);
        chk("cbp_to", timed_out, 0);
        eb = '{0, 2, 5, 0, 0, 0};
        ec = '{0, 0, 2, 0, 0, 0};
        check_blocks("cbp", 3, eb, ec);
        chk("cbp_cnt", last_cnt, 3);
        chk("cbp_rel", n_rel, 3);
        chk("cbp_flag", intra_bad, 0);
        step();

        // Non-intra, nothing coded: SEL then DONE.
        run_mb(1'b0, 6'b000000, 0, 1'b0);
        chk("empty_to", timed_out, 0);
        chk("empty_done_cyc", done_cyc, 2);
        chk("empty_busy", busy_cyc, 2);
        chk("empty_en", n_en, 0);
        chk("empty_rel", n_rel, 0);
        chk("empty_cnt", last_cnt, 0);
        step();
        chk("empty_idle", bus.mb_busy, 0);

        // Buffer late by 10 cycles; h_end without h_en must not advance.
        bus.buf_valid = 1'b0;
        bus.mb_intra = 1'b0; bus.mb_cbp = 6'b000001; bus.mb_start = 1'b1;
        step();
        bus.mb_start = 1'b0; bus.mb_cbp = '0;
        early = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.rle_en) early++;
            step();
        end
        chk("late_early_en", early, 0);
        chk("late_busy", bus.mb_busy, 1);
        bus.buf_valid = 1'b1;
        step();
        chk("late_en", bus.rle_en, 1);
        chk("late_blk", bus.buf_blk, 0);
        bus.h_end = 1'b1; bus.h_en = 1'b0;
        early = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.buf_release) early++;
        end
        chk("hend_only_rel", early, 0);
        bus.h_en = 1'b1;
        step();
        bus.h_en = 1'b0; bus.h_end = 1'b0;
        chk("hen_rel", bus.buf_release, 1);
        cnt = 0;
        for (int i = 0; i < 10 && cnt == 0; i++) begin
            step();
            if (bus.mb_done) begin
                cnt = 1;
                chk("late_cnt", bus.blk_cnt, 1);
            end
        end
        chk("late_done", cnt, 1);
        step();

        // Reset in the RUN of block 2, then a clean restart.
        run_mb(1'b1, 6'b000000, 3, 1'b0);
        chk("abort_to", timed_out, 0);
        chk("abort_blk", seen_blk[2], 2);
        step();
        rst = 1'b0;
        chk("abort_busy", bus.mb_busy, 0);
        chk("abort_cnt", bus.blk_cnt, 0);
        chk("abort_done", bus.mb_done, 0);
        chk("abort_rel", bus.buf_release, 0);
        chk("abort_intra", bus.rle_intra, 0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.mb_done || bus.buf_release || bus.mb_busy) cnt++;
        end
        chk("abort_quiet", cnt, 0);
        run_mb(1'b1, 6'b000000, 0, 1'b0);
        chk("restart_to", timed_out, 0);
        eb = '{0, 1, 2, 3, 4, 5};
        ec = '{0, 0, 0, 0, 1, 2};
        check_blocks("restart", 6, eb, ec);
        chk("restart_cnt", last_cnt, 6);
        step();

        // Stray mb_start during RUN must not disturb the in-flight mask.
        run_mb(1'b0, 6'b100101, 0, 1'b1);
        chk("glitch_to", timed_out, 0);
        eb = '{0, 2, 5, 0, 0, 0};
        ec = '{0, 0, 2, 0, 0, 0};
        check_blocks("glitch", 3, eb, ec);
        chk("glitch_cnt", last_cnt, 3);
        chk("glitch_flag", intra_bad, 0);
        chk("glitch_done", n_done, 1);
        step();
        chk("glitch_idle", bus.mb_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mb_sched.md
MB_SCHED -- requirements
Module: mb_sched

Interface
REQ-001 SHALL have port clk, input, 1; sole clock, all state rising-edge.
REQ-002 SHALL have port reset, input, 1; synchronous, active-high.
REQ-003 SHALL have port mb_start, input, 1; start-of-macroblock pulse, sampled only in IDLE.
REQ-004 SHALL have port mb_intra, input, 1; macroblock is intra-coded, sampled with mb_start.
REQ-005 SHALL have port mb_cbp, input, 6; coded-block pattern, bit i = block i coded (0-3 Y, 4 Cb, 5 Cr), sampled with mb_start.
REQ-006 SHALL have port mb_busy, output, 1; high from the cycle after an accepted mb_start through the DONE cycle.
REQ-007 SHALL have port mb_done, output, 1; one-cycle end-of-macroblock pulse.
REQ-008 SHALL have port buf_valid, input, 1; DCT block buffer for buf_blk holds a complete block.
REQ-009 SHALL have port buf_blk, output, 3; current block index 0-5.
REQ-010 SHALL have port buf_release, output, 1; one-cycle pulse, buffer for buf_blk is free.
REQ-011 SHALL have port rle_rdy, input, 1; run-length encoder idle.
REQ-012 SHALL have port rle_en, output, 1; one-cycle encoder start.
REQ-013 SHALL have port rle_intra, output, 1; latched intra flag to encoder, stable while mb_busy.
REQ-014 SHALL have ports h_en and h_end, input, 1 each; snooped encoder-to-hash-table strobe and end-of-block flag.
REQ-015 SHALL have port blk_cc, output, 2; colour component of buf_blk: 0 luma, 1 Cb, 2 Cr.
REQ-016 SHALL have port blk_cnt, output, 3; number of blocks completed in current macroblock.

Function
REQ-017 SHALL implement states IDLE, SEL, WAIT, LAUNCH, RUN, RELEASE, DONE.
REQ-018 IDLE: mb_start SHALL latch mb_intra and mask = (mb_intra ? 6'b111111 : mb_cbp), clear blk_cnt, and go to SEL; mb_start SHALL be ignored in every other state.
REQ-019 SEL: SHALL set buf_blk to the lowest set bit of mask at or above the search pointer (0 on entry from IDLE) and go to WAIT; if none, go to DONE.
REQ-020 WAIT: SHALL hold until buf_valid and rle_rdy are both high in the same cycle, then go to LAUNCH.
REQ-021 LAUNCH: SHALL assert rle_en for exactly this one cycle, then go to RUN.
REQ-022 RUN: SHALL hold until h_en and h_end are both high in the same cycle, then go to RELEASE; h_end without h_en SHALL NOT advance.
REQ-023 RELEASE: SHALL pulse buf_release one cycle, increment blk_cnt, set search pointer to buf_blk+1, and go to SEL; pointer 6 SHALL yield no candidate.
REQ-024 DONE: SHALL pulse mb_done one cycle, hold blk_cnt, and return to IDLE.
REQ-025 Non-intra with mb_cbp = 0 SHALL go IDLE, SEL, DONE with no rle_en and no buf_release; mb_done occurs 2 cycles after mb_start.
REQ-026 blk_cc SHALL be combinational from buf_blk: 0-3 -> 0, 4 -> 1, 5 -> 2.
REQ-027 Minimum per-block overhead SHALL be 4 cycles (SEL, WAIT with inputs high, LAUNCH, RELEASE) plus RUN duration.
REQ-028 buf_valid dropping during RUN SHALL be ignored; the block SHALL complete.

Reset
REQ-029 reset SHALL force IDLE, mask=0, pointer=0, buf_blk=0, blk_cnt=0, rle_intra=0, and mb_busy, mb_done, rle_en, buf_release low on the next edge.
REQ-030 reset in any state, including mid-RUN, SHALL abort without buf_release or mb_done pulses.
REQ-031 reset SHALL take priority over every simultaneous input.

Structure
REQ-032 State encoding, block count constant (6) and colour-component codes SHALL live in shared package mpeg2_pkg.
REQ-033 The next-coded-block search (mask, pointer -> index, found) SHALL be sub-module mb_blk_sel, purely combinational.
REQ-034 All outputs except blk_cc SHALL be registered or decoded from the state register only, with no input-to-output combinational path.

Verification
REQ-035 Intra, cbp=6'b000000, buf_valid=1, rle_rdy=1, h_end+h_en 5 cycles after each rle_en -> six rle_en, buf_blk 0..5, blk_cc 0,0,0,0,1,2, blk_cnt=6, one mb_done.
REQ-036 Non-intra, cbp=6'b100101 -> blocks 0,2,5 only, rle_intra=0, blk_cnt=3, three buf_release pulses.
REQ-037 Non-intra, cbp=0 -> mb_done 2 cycles after mb_start, no rle_en, mb_busy high 2 cycles.
REQ-038 buf_valid low 10 cycles then high, rle_rdy high -> rle_en exactly 1 cycle after buf_valid rises; h_end with h_en=0 for 3 cycles -> no buf_release until h_en rises.
REQ-039 reset asserted mid-RUN of block 2 -> next cycle IDLE, mb_busy=0, blk_cnt=0, no mb_done; fresh mb_start restarts at block 0.
REQ-040 mb_start pulsed during RUN with cbp=6'b000001 -> ignored; in-flight mask unchanged.
